// File: rtl/seq_control.sv
// seq_control: multicycle opcode sequencer with memory/ALU handshakes, traps and fast untaken branches
package seq_control_pkg;
  typedef logic [6:0] opcode_t;
  localparam opcode_t OP_LOAD     = 7'b0000011;
  localparam opcode_t OP_MISC_MEM = 7'b0001111;
  localparam opcode_t OP_IMM      = 7'b0010011;
  localparam opcode_t OP_AUIPC    = 7'b0010111;
  localparam opcode_t OP_STORE    = 7'b0100011;
  localparam opcode_t OP_OP       = 7'b0110011;
  localparam opcode_t OP_LUI      = 7'b0110111;
  localparam opcode_t OP_BRANCH   = 7'b1100011;
  localparam opcode_t OP_JALR     = 7'b1100111;
  localparam opcode_t OP_JAL      = 7'b1101111;
  localparam opcode_t OP_SYSTEM   = 7'b1110011;
  localparam opcode_t OP_INIT     = 7'b0000000;
  typedef enum logic [2:0] {
    ALUC_NONE, ALUC_OPEXE, ALUC_RS1_IMM, ALUC_BRANCH_OP, ALUC_PC_IMM, ALUC_PC_4
  } alu_ctrl_t;
endpackage

module seq_control import seq_control_pkg::*; #(
  parameter int STEP_W = 2,
  parameter int FAST_BRANCH = 1,
  parameter int TRAP_SYSTEM = 1
) (
  input  logic clk,
  input  logic rst,
  input  opcode_t fetch_opcode,
  input  logic mem_ack,
  input  logic alu_done,
  input  logic br_taken,
  output logic mem_req,
  output logic mem_we,
  output logic update_instr,
  output logic rf_rs1,
  output logic rf_rs2,
  output logic rf_wren,
  output alu_ctrl_t alu_ctrl,
  output logic alu_start,
  output logic update_pc,
  output logic [1:0] pc_sel,
  output logic trap,
  output logic retired
);
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_TRAP  = 2'd2;
  localparam logic [STEP_W-1:0] ST1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] ST2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] ST3 = STEP_W'(3);
  logic [1:0] state;
  logic [STEP_W-1:0] step;
  opcode_t cur_op;
  logic alu_busy, taken_q, wren, upc, last, done, trap_op;
  logic s0, s1, s2, s3;
  assign s0 = step == '0;
  assign s1 = step == ST1;
  assign s2 = step == ST2;
  assign s3 = step == ST3;
  assign trap_op = !(fetch_opcode inside {OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
                     OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM})
                   || (TRAP_SYSTEM != 0 && fetch_opcode == OP_SYSTEM);
  always_comb begin
    mem_req = 1'b0;
    mem_we = 1'b0;
    update_instr = 1'b0;
    rf_rs1 = 1'b0;
    rf_rs2 = 1'b0;
    alu_ctrl = ALUC_NONE;
    pc_sel = 2'b00;
    trap = 1'b0;
    wren = 1'b0;
    upc = 1'b0;
    last = 1'b0;
    if (!rst) case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        update_instr = mem_ack;
      end
      S_TRAP: begin
        trap = 1'b1;
        upc = 1'b1;
        pc_sel = 2'b10;
      end
      S_EXEC: case (cur_op)
        OP_OP: begin
          rf_rs1 = s0;
          rf_rs2 = s1;
          alu_ctrl = s2 ? ALUC_OPEXE : ALUC_NONE;
          wren = s2;
          upc = s2;
          last = s2;
        end
        OP_IMM: begin
          rf_rs1 = s0;
          alu_ctrl = s1 ? ALUC_OPEXE : ALUC_NONE;
          wren = s1;
          upc = s1;
          last = s1;
        end
        OP_LOAD: begin
          rf_rs1 = s0;
          alu_ctrl = s1 ? ALUC_RS1_IMM : ALUC_NONE;
          mem_req = s2;
          wren = s2;
          upc = s2;
          last = s2;
        end
        OP_STORE: begin
          rf_rs1 = s0;
          rf_rs2 = s1;
          alu_ctrl = s1 ? ALUC_RS1_IMM : ALUC_NONE;
          mem_req = s2;
          mem_we = s2;
          upc = s2;
          last = s2;
        end
        OP_BRANCH: begin
          rf_rs1 = s0;
          rf_rs2 = s1;
          alu_ctrl = s2 ? ALUC_BRANCH_OP : s3 ? ALUC_PC_IMM : ALUC_NONE;
          upc = s3 || (FAST_BRANCH != 0 && s2 && !br_taken);
          last = upc;
          pc_sel = {1'b0, s3 && taken_q};
        end
        OP_JAL: begin
          alu_ctrl = s0 ? ALUC_PC_4 : ALUC_PC_IMM;
          wren = s0;
          upc = s1;
          last = s1;
          pc_sel = {1'b0, s1};
        end
        OP_JALR: begin
          rf_rs1 = s0;
          alu_ctrl = s1 ? ALUC_PC_4 : s2 ? ALUC_RS1_IMM : ALUC_NONE;
          wren = s1;
          upc = s2;
          last = s2;
          pc_sel = {1'b0, s2};
        end
        OP_AUIPC: begin
          alu_ctrl = ALUC_PC_IMM;
          wren = 1'b1;
          upc = 1'b1;
          last = 1'b1;
        end
        OP_LUI: begin
          wren = 1'b1;
          upc = 1'b1;
          last = 1'b1;
        end
        OP_MISC_MEM, OP_SYSTEM: begin
          upc = 1'b1;
          last = 1'b1;
        end
        default: last = 1'b1;
      endcase
      default: ;
    endcase
  end
  assign done = !((mem_req && !mem_ack) || (alu_ctrl == ALUC_OPEXE && !alu_done));
  assign rf_wren = wren && done;
  assign update_pc = upc && done;
  assign retired = last && done;
  assign alu_start = alu_ctrl == ALUC_OPEXE && !alu_busy;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_FETCH;
      step <= '0;
      cur_op <= OP_INIT;
      alu_busy <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      alu_busy <= alu_ctrl == ALUC_OPEXE && !alu_done;
      if (state == S_EXEC && s2) taken_q <= br_taken;
      case (state)
        S_FETCH: if (mem_ack) begin
          cur_op <= fetch_opcode;
          step <= '0;
          state <= trap_op ? S_TRAP : S_EXEC;
        end
        S_EXEC: if (done) begin
          step <= last ? step : step + ST1;
          state <= last ? S_FETCH : S_EXEC;
        end
        default: state <= S_FETCH;
      endcase
    end
endmodule

// File: tb/tb_seq_control.sv
// tb_seq_control: randomized instruction stream checked against per-instruction expectations
module tb_seq_control;
  import seq_control_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  opcode_t fetch_opcode = '0;
  logic mem_ack = 1'b0, alu_done = 1'b0, br_taken = 1'b0;
  logic mem_req, mem_we, update_instr, rf_rs1, rf_rs2, rf_wren, alu_start, update_pc, trap, retired;
  alu_ctrl_t alu_ctrl;
  logic [1:0] pc_sel;
  int checks = 0, errors = 0;

  seq_control dut (
    .clk(clk), .rst(rst), .fetch_opcode(fetch_opcode), .mem_ack(mem_ack), .alu_done(alu_done),
    .br_taken(br_taken), .mem_req(mem_req), .mem_we(mem_we), .update_instr(update_instr),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_wren(rf_wren), .alu_ctrl(alu_ctrl), .alu_start(alu_start),
    .update_pc(update_pc), .pc_sel(pc_sel), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs();
    return int'({mem_req, mem_we, update_instr, rf_rs1, rf_rs2, rf_wren, alu_start, update_pc,
                 pc_sel, trap, retired, alu_ctrl});
  endfunction

  // Instruction-level expectations: base latency and how many cycles each strobe should appear.
  task automatic model(input opcode_t op, input logic tk, output int lat, output int rs1,
                       output int rs2, output int wr, output int mem, output int opx,
                       output int ps, output int trp);
    rs1 = 0; rs2 = 0; wr = 0; mem = 0; opx = 0; ps = 0; trp = 0;
    case (op)
      OP_OP:       begin lat = 4; rs1 = 1; rs2 = 1; wr = 1; opx = 1; end
      OP_IMM:      begin lat = 3; rs1 = 1; wr = 1; opx = 1; end
      OP_LOAD:     begin lat = 4; rs1 = 1; wr = 1; mem = 1; end
      OP_STORE:    begin lat = 4; rs1 = 1; rs2 = 1; mem = 2; end
      OP_BRANCH:   begin lat = tk ? 5 : 4; rs1 = 1; rs2 = 1; ps = int'(tk); end
      OP_JAL:      begin lat = 3; wr = 1; ps = 1; end
      OP_JALR:     begin lat = 4; rs1 = 1; wr = 1; ps = 1; end
      OP_AUIPC, OP_LUI: begin lat = 2; wr = 1; end
      OP_MISC_MEM: lat = 2;
      default:     begin lat = 2; ps = 2; trp = 1; end
    endcase
  endtask

  task automatic run(input opcode_t op, input int wf, input int wd, input int al, input logic tk);
    int lat, rs1, rs2, wr, mem, opx, ps, trp;
    int cyc = 0, mcnt = 0, ridx = 0, acnt = 0, bad = 0, got_ps = -1;
    int n_as = 0, n_wr = 0, n_up = 0, n_we = 0, n_mr = 0, n_rs1 = 0, n_rs2 = 0, n_tr = 0, n_ret = 0;
    logic fin = 1'b0;
    string t;
    model(op, tk, lat, rs1, rs2, wr, mem, opx, ps, trp);
    t = $sformatf("op=%02h", op);
    fetch_opcode = op;
    while (!fin && cyc < 100) begin
      @(negedge clk);
      mem_ack = 1'b0;
      alu_done = 1'b0;
      br_taken = 1'($urandom);
      #1;
      if (alu_start) acnt = 0;
      if (alu_ctrl == ALUC_BRANCH_OP) br_taken = tk;
      mem_ack = mem_req ? (mcnt == (ridx == 0 ? wf : wd)) : 1'($urandom);
      alu_done = alu_ctrl == ALUC_OPEXE ? (acnt == al - 1) : 1'($urandom);
      #1;
      cyc++;
      if (((mem_req && !mem_ack) || (alu_ctrl == ALUC_OPEXE && !alu_done))
          && (rf_wren || update_pc || retired)) bad++;
      n_as += int'(alu_start);
      n_wr += int'(rf_wren);
      n_up += int'(update_pc);
      n_we += int'(mem_req && mem_we);
      n_mr += int'(mem_req);
      n_rs1 += int'(rf_rs1);
      n_rs2 += int'(rf_rs2);
      n_tr += int'(trap);
      n_ret += int'(retired);
      if (update_pc) got_ps = int'(pc_sel);
      if (mem_req) begin
        if (mem_ack) begin mcnt = 0; ridx++; end
        else mcnt++;
      end
      if (alu_ctrl == ALUC_OPEXE) acnt++;
      fin = retired || trap;
    end
    check({t, " done"}, int'(fin), 1);
    check({t, " latency"}, cyc, lat + wf + (mem != 0 ? wd : 0) + (opx != 0 ? al - 1 : 0));
    check({t, " alu_start"}, n_as, opx);
    check({t, " rf_wren"}, n_wr, wr);
    check({t, " update_pc"}, n_up, 1);
    check({t, " pc_sel"}, got_ps, ps);
    check({t, " mem_req"}, n_mr, wf + 1 + (mem != 0 ? wd + 1 : 0));
    check({t, " mem_we"}, n_we, mem == 2 ? wd + 1 : 0);
    check({t, " rs1"}, n_rs1, rs1);
    check({t, " rs2"}, n_rs2, rs2);
    check({t, " trap"}, n_tr, trp);
    check({t, " retired"}, n_ret, 1 - trp);
    check({t, " wait_strobe"}, bad, 0);
  endtask

  opcode_t ops[11] = '{OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC,
                       OP_LUI, OP_MISC_MEM, OP_SYSTEM};

  initial begin
    int seen_we;
    repeat (3) @(negedge clk);
    check("rst_outs", outs(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_release_mem_req", int'(mem_req), 1);
    run(OP_IMM, 0, 0, 1, 1'b0);
    run(OP_LOAD, 0, 3, 1, 1'b0);
    run(OP_BRANCH, 0, 0, 1, 1'b0);
    run(OP_BRANCH, 1, 0, 1, 1'b1);
    run(OP_OP, 0, 0, 6, 1'b0);
    run(7'b0000000, 0, 0, 1, 1'b0);
    run(OP_SYSTEM, 2, 0, 1, 1'b0);
    // Abort a STORE while its data write is stalled.
    fetch_opcode = OP_STORE;
    seen_we = 0;
    for (int i = 0; i < 20 && seen_we < 2; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      #1 mem_ack = mem_req && !mem_we;
      seen_we += int'(mem_we);
    end
    check("abort_reached_s2", seen_we, 2);
    mem_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 check("abort_outs", outs(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("abort_fetch_req", int'(mem_req), 1);
    check("abort_no_write", int'(mem_we), 0);
    run(OP_JALR, 0, 0, 1, 1'b0);
    for (int n = 0; n < 60; n++) begin
      opcode_t op = $urandom_range(0, 3) == 0 ? opcode_t'($urandom_range(0, 127))
                                              : ops[$urandom_range(0, 10)];
      run(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4),
          1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_control.md
# seq_control

Parametrised multicycle sequencer for the suro-v core. It latches the opcode at instruction fetch and steps through a per-opcode micro-schedule, driving register-file, ALU, PC and memory strobes. Unlike the fixed-timing controller it replaces, it:
- waits on a memory handshake (`mem_req`/`mem_ack`) with arbitrary wait states;
- waits on a multicycle ALU (`alu_start`/`alu_done`);
- traps on illegal or SYSTEM opcodes;
- can retire untaken branches one step early.

## Interface
Parameters:
- STEP_W, 2, step counter width; must be ≥2.
- FAST_BRANCH, 1, when 1 an untaken branch finishes at step 2.
- TRAP_SYSTEM, 1, when 1 SYSTEM opcodes trap; when 0 they execute as a one-step nop.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- fetch_opcode  in  opcode_t  opcode field of the memory read data; valid only when `mem_ack`=1 in FETCH
- mem_ack  in  1  memory has completed the current request
- alu_done  in  1  ALU has completed the OPEXE operation
- br_taken  in  1  branch comparison result; valid in BRANCH step 2
- mem_req  out  1  memory request; held until `mem_ack`
- mem_we  out  1  write qualifier for `mem_req`
- update_instr  out  1  instruction register captures read data
- rf_rs1, rf_rs2  out  1  register-file read strobes
- rf_wren  out  1  register-file write
- alu_ctrl  out  alu_ctrl_t  ALU operand/operation select
- alu_start  out  1  one-cycle start pulse for an OPEXE step
- update_pc  out  1  PC load
- pc_sel  out  2  PC source: 00 = pc+4, 01 = ALU result, 10 = trap vector
- trap  out  1  trap taken
- retired  out  1  one-cycle pulse when an instruction completes

## Operation
- States:
  - FETCH: `mem_req`=1, `mem_we`=0. On `mem_ack`, assert `update_instr`, latch `fetch_opcode` into `cur_op`, clear `step`, go to EXEC.
  - EXEC: run the schedule for `cur_op`, indexed by `step`.
  - TRAP: lasts one cycle, then FETCH.
- Step advance:
  - A step holds while it has `mem_req`=1 and `mem_ack`=0.
  - A step holds while it uses OPEXE and `alu_done`=0.
  - Otherwise the step lasts one cycle.
  - On completing the last step: pulse `retired`, go to FETCH.
- Schedule. Steps are separated by `;`. ALU selects are ALUC_*. Every strobe not listed is 0.
  - OP: s0 `rf_rs1`; s1 `rf_rs2`; s2 OPEXE, `rf_wren`, `update_pc`, `pc_sel`=00.
  - IMM: s0 `rf_rs1`; s1 OPEXE, `rf_wren`, `update_pc`, `pc_sel`=00.
  - LOAD: s0 `rf_rs1`; s1 RS1_IMM; s2 `mem_req`, `rf_wren` (asserted in the `mem_ack` cycle only), `update_pc`, `pc_sel`=00.
  - STORE: s0 `rf_rs1`; s1 `rf_rs2`, RS1_IMM; s2 `mem_req`, `mem_we`, `update_pc`, `pc_sel`=00.
  - BRANCH: s0 `rf_rs1`; s1 `rf_rs2`; s2 BRANCH_OP; s3 PC_IMM, `update_pc`, `pc_sel` = taken ? 01 : 00.
    - If FAST_BRANCH=1 and `br_taken`=0 in s2: assert `update_pc`, `pc_sel`=00 in s2 and retire there.
  - JAL: s0 PC_4, `rf_wren`; s1 PC_IMM, `update_pc`, `pc_sel`=01.
  - JALR: s0 `rf_rs1`; s1 PC_4, `rf_wren`; s2 RS1_IMM, `update_pc`, `pc_sel`=01.
  - AUIPC: s0 PC_IMM, `rf_wren`, `update_pc`, `pc_sel`=00.
  - LUI: s0 NONE (immediate pass-through), `rf_wren`, `update_pc`, `pc_sel`=00.
  - MISC_MEM: s0 `update_pc`, `pc_sel`=00.
  - SYSTEM: goes to TRAP if TRAP_SYSTEM=1; otherwise behaves as MISC_MEM.
  - Any other opcode: TRAP.
- TRAP cycle: `trap`=1, `update_pc`=1, `pc_sel`=10, `retired`=0.
- Strobe timing:
  - `update_pc` and `rf_wren` are asserted only in the cycle the step completes, never during wait cycles.
  - `alu_start` pulses only in the first cycle of each OPEXE step.
- `alu_ctrl` is ALUC_NONE in FETCH, TRAP and reset.

## Timing
- Reset:
  - While `rst`=1, every output is 0 and `alu_ctrl`=ALUC_NONE.
  - The next state is FETCH, `step`=0, `cur_op`=OP_INIT.
  - `mem_req`=1 in the first cycle after `rst` falls.
  - `rst` asserted mid-instruction or mid-wait aborts it; no `retired` pulse is produced.
- Latency with zero wait states is FETCH (1 cycle) plus the step count:
  - OP: 4
  - IMM: 3
  - LOAD: 4
  - STORE: 4
  - BRANCH: 5, or 4 when fast-untaken
  - JAL: 3
  - JALR: 4
  - AUIPC / LUI / MISC_MEM: 2
  - TRAP: 2
- Each memory wait cycle adds 1 cycle; each cycle of `alu_done` latency beyond the first adds 1 cycle.
- `mem_ack` is ignored when `mem_req`=0. An ack arriving in the same cycle as the request completes that step.
- `step` never exceeds 3. The counter wraps to 0 only through FETCH.

## Test plan
- Reset release → `mem_req`=1 on the first cycle. `fetch_opcode`=OP_IMM with immediate ack, `alu_done`=1 → `rf_wren`+`update_pc` 2 cycles after the ack, `retired` pulse, then FETCH.
- OP_LOAD with `mem_ack` delayed 3 cycles in s2 → `mem_req` held 4 cycles; `rf_wren`/`update_pc`/`retired` only in the ack cycle.
- OP_BRANCH, FAST_BRANCH=1: `br_taken`=0 → retires at s2 with `pc_sel`=00. `br_taken`=1 → s3 asserts `pc_sel`=01.
- OP_OP with `alu_done` asserted 5 cycles after `alu_start` → a single `alu_start` pulse; `rf_wren` in the `alu_done` cycle only.
- Illegal opcode 7'b0000000, and OP_SYSTEM with TRAP_SYSTEM=1 → one cycle with `trap`=1, `update_pc`=1, `pc_sel`=10, `retired`=0, then FETCH.
- `rst` asserted during a STORE s2 wait → all outputs 0 the next cycle, no write issued after reset, restart at FETCH.
